// File: rtl/flops_pkg.sv
// flops_pkg: shared constants and stage record type for the elastic flop pipe.
// Optional macro: FLOPS_PARITY_EN adds a parity bit to each stage record.
package flops_pkg;

    localparam int FLOPS_DEF_WIDTH = 32;
    localparam int FLOPS_DEF_DEPTH = 2;

    // Control half of a stage record. The data half is width-parameterised
    // and lives next to it in flops_pipe_stage.
    typedef struct packed {
        logic valid;
`ifdef FLOPS_PARITY_EN
        logic parity;
`endif
    } flops_stage_ctl_t;

endpackage

// File: rtl/flops_pipe_stage.sv
// flops_pipe_stage: one elastic register stage (valid, data, optional parity).
// Optional macro: FLOPS_PARITY_EN adds up_parity/parity ports and storage.
// Ports:
//   clk_2f, reset_L   clock, asynchronous active-low reset
//   flush             synchronous clear of the valid bit (data holds)
//   load              stage may take the upstream record this cycle
//   up_valid/up_data  upstream record
//   valid/data        registered stage contents
module flops_pipe_stage
    import flops_pkg::*;
#(
    parameter int WIDTH = FLOPS_DEF_WIDTH
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
`ifdef FLOPS_PARITY_EN
    input  logic             up_parity,
    output logic             parity,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    typedef struct packed {
        flops_stage_ctl_t ctl;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t q;

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            q <= '0;
        end else if (flush) begin
            q.ctl.valid <= 1'b0;
        end else if (load) begin
            q.ctl.valid <= up_valid;
            // A bubble moving through leaves the old word in place.
            if (up_valid) begin
                q.data <= up_data;
`ifdef FLOPS_PARITY_EN
                q.ctl.parity <= up_parity;
`endif
            end
        end
    end

    assign valid = q.ctl.valid;
    assign data  = q.data;
`ifdef FLOPS_PARITY_EN
    assign parity = q.ctl.parity;
`endif

endmodule

// File: rtl/flops_pipe_elastic.sv
// flops_pipe_elastic: DEPTH-stage elastic valid/ready pipeline with bubble
// collapse, synchronous flush and a registered occupancy counter.
// Optional macro: FLOPS_PARITY_EN enables per-stage even parity and parity_err.
// Ports:
//   clk_2f, reset_L        clock, asynchronous active-low reset
//   flush                  clear all stages at the next edge
//   valid_in, data_in      upstream word; ready_out = block can accept
//   valid_out, data_out_Flops  last-stage word; ready_in = downstream accepts
//   occupancy              number of valid stages (registered)
//   parity_err             one-cycle pulse after an emit with bad parity
module flops_pipe_elastic
    import flops_pkg::*;
#(
    parameter  int WIDTH = FLOPS_DEF_WIDTH,
    parameter  int DEPTH = FLOPS_DEF_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out_Flops,
    input  logic             ready_in,
    output logic [CW-1:0]    occupancy,
    output logic             parity_err
);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0]            up_v;
    logic [DEPTH-1:0][WIDTH-1:0] up_d;
    logic [DEPTH:0]              rdy;
`ifdef FLOPS_PARITY_EN
    logic [DEPTH-1:0]            p;
    logic [DEPTH-1:0]            up_p;
`endif

    // Ready ripples back from the consumer; an empty stage is always ready,
    // which is what lets bubbles collapse behind a stalled output.
    assign rdy[DEPTH] = ready_in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign rdy[i] = !v[i] || rdy[i+1];

        if (i == 0) begin : g_head
            assign up_v[i] = valid_in;
            assign up_d[i] = data_in;
`ifdef FLOPS_PARITY_EN
            assign up_p[i] = ^data_in;
`endif
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
`ifdef FLOPS_PARITY_EN
            assign up_p[i] = p[i-1];
`endif
        end

        flops_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk_2f   (clk_2f),
            .reset_L  (reset_L),
            .flush    (flush),
            .load     (rdy[i]),
            .up_valid (up_v[i]),
            .up_data  (up_d[i]),
`ifdef FLOPS_PARITY_EN
            .up_parity(up_p[i]),
            .parity   (p[i]),
`endif
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign ready_out      = rdy[0];
    assign valid_out      = v[DEPTH-1];
    assign data_out_Flops = d[DEPTH-1];

    logic accept, emit;
    assign accept = valid_in && ready_out;
    assign emit   = valid_out && ready_in;

    // Counter tracks popcount(v): a flush-cycle accept is dropped by the
    // flush itself, so flush simply forces zero.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (accept && !emit) begin
            occupancy <= occupancy + CW'(1);
        end else if (emit && !accept) begin
            occupancy <= occupancy - CW'(1);
        end
    end

`ifdef FLOPS_PARITY_EN
    // Not gated by flush: an emit in a flush cycle is still delivered.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= emit && ((^d[DEPTH-1]) != p[DEPTH-1]);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_flops_pipe_elastic.sv
// Scoreboard bench for flops_pipe_elastic (DEPTH = 4).
module tb_flops_pipe_elastic;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk_2f   = 1'b0;
    logic             reset_L  = 1'b0;
    logic             flush    = 1'b0;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] data_in  = '0;
    logic             ready_in = 1'b0;
    logic             ready_out, valid_out, parity_err;
    logic [WIDTH-1:0] data_out_Flops;
    logic [CW-1:0]    occupancy;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   lat_mode = 1'b0;

    flops_pipe_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_2f        (clk_2f),
        .reset_L       (reset_L),
        .flush         (flush),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .ready_out     (ready_out),
        .valid_out     (valid_out),
        .data_out_Flops(data_out_Flops),
        .ready_in      (ready_in),
        .occupancy     (occupancy),
        .parity_err    (parity_err)
    );

    always #5 clk_2f = ~clk_2f;
    always @(posedge clk_2f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every emitted word must be the oldest outstanding accept.
    always @(negedge clk_2f) begin
        if (reset_L && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check("emit_unexpected", {32'd0, data_out_Flops}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("emit_data", data_out_Flops, e.data);
                if (e.lat) check("latency", cyc - e.cyc, DEPTH);
            end
        end
        if (reset_L) check("parity_err", parity_err, 0);
    end

    // One clock of stimulus; accepts are recorded just before the edge.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit rdy, input bit fl);
        valid_in = v;
        data_in  = d;
        ready_in = rdy;
        flush    = fl;
        @(negedge clk_2f);
        if (valid_in && ready_out && !flush) begin
            exp_t e;
            e.data = d;
            e.cyc  = cyc;
            e.lat  = lat_mode;
            exp_q.push_back(e);
        end
        @(posedge clk_2f);
        #1;
        if (fl) exp_q.delete();
        check("occupancy", occupancy, exp_q.size());
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset held with a live input.
        valid_in = 1'b1;
        data_in  = 32'hA5A5_A5A5;
        ready_in = 1'b1;
        repeat (2) @(posedge clk_2f);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out_Flops, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_ready_out", ready_out, 1);
        valid_in = 1'b0;
        reset_L  = 1'b1;
        @(posedge clk_2f);
        #1;

        // Streaming: three back-to-back words, fixed latency, no gaps.
        lat_mode = 1'b1;
        step(1'b1, 32'd1, 1'b1, 1'b0);
        step(1'b1, 32'd2, 1'b1, 1'b0);
        step(1'b1, 32'd3, 1'b1, 1'b0);
        lat_mode = 1'b0;
        drain(DEPTH + 1);

        // Backpressure: fill completely with the output stalled.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
        check("full_ready_out", ready_out, 0);
        check("full_occupancy", occupancy, DEPTH);
        step(1'b1, 32'hDEAD_0001, 1'b0, 1'b0);      // refused, stages hold
        check("full_hold_data", data_out_Flops, 32'h100);
        ready_in = 1'b1;
        #1;
        check("full_ready_through", ready_out, 1);
        step(1'b1, 32'h200, 1'b1, 1'b0);            // simultaneous accept and emit
        check("full_swap_occ", occupancy, DEPTH);
        drain(DEPTH + 2);

        // Bubble collapse: lone word stalls at the output, then the rest fill.
        step(1'b1, 32'h300, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) step(1'b1, 32'h300 + i, 1'b0, 1'b0);
        check("bubble_occ", occupancy, DEPTH);
        drain(DEPTH + 2);

        // Flush with three words held and an input offered.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + i, 1'b0, 1'b0);
        check("pre_flush_occ", occupancy, 3);
        step(1'b1, 32'hBAD0_0000, 1'b0, 1'b1);
        check("flush_valid_out", valid_out, 0);
        check("flush_occ", occupancy, 0);
        drain(DEPTH + 2);

        // Flush on a full pipe while the head word is emitted.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h600 + i, 1'b0, 1'b0);
        step(1'b1, 32'hBAD0_0001, 1'b1, 1'b1);
        check("flush_emit_valid", valid_out, 0);
        drain(DEPTH + 2);

        // Asynchronous reset mid-stream, between clock edges.
        step(1'b1, 32'h500, 1'b1, 1'b0);
        step(1'b1, 32'h501, 1'b1, 1'b0);
        valid_in = 1'b0;
        ready_in = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        check("arst_valid_out", valid_out, 0);
        check("arst_data_out", data_out_Flops, 0);
        check("arst_occupancy", occupancy, 0);
        check("arst_ready_out", ready_out, 1);
        exp_q.delete();
        #3;
        reset_L = 1'b1;
        @(posedge clk_2f);
        #1;
        step(1'b1, 32'h700, 1'b1, 1'b0);

        // Final bounded drain; anything left outstanding is a lost word.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, '0, 1'b1, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
